// File: rtl/voq_dequeue_ctrl_if.sv
// Dequeue-side handshake bundle for voq_dequeue_ctrl.
// Carries three groups of signals:
//   - scheduler grant: sched_valid/sched_sel/sched_ready
//   - VMU pop port: is_empty, voq_dequeue_en/sel, meta_out
//   - segment read stream toward the crossbar: seg_*
// The master modport is the controller side; slave is the environment side.
interface voq_dequeue_ctrl_if #(
  parameter int EGRESS_CNT = 4,
  parameter int ADDR_WIDTH = 10
);
  localparam int SEL_W = (EGRESS_CNT > 1) ? $clog2(EGRESS_CNT) : 1;

  logic                  sched_valid;
  logic [SEL_W-1:0]      sched_sel;
  logic                  sched_ready;
  logic [EGRESS_CNT-1:0] is_empty;
  logic                  voq_dequeue_en;
  logic [SEL_W-1:0]      voq_dequeue_sel;
  logic [31:0]           meta_out;
  logic                  seg_valid;
  logic [ADDR_WIDTH-1:0] seg_addr;
  logic                  seg_first;
  logic                  seg_last;
  logic                  seg_ready;

  modport master (
    input  sched_valid, sched_sel, is_empty, meta_out, seg_ready,
    output sched_ready, voq_dequeue_en, voq_dequeue_sel,
           seg_valid, seg_addr, seg_first, seg_last
  );

  modport slave (
    output sched_valid, sched_sel, is_empty, meta_out, seg_ready,
    input  sched_ready, voq_dequeue_en, voq_dequeue_sel,
           seg_valid, seg_addr, seg_first, seg_last
  );
endinterface

// File: rtl/voq_dequeue_ctrl.sv
// VOQ dequeue controller.
// Accepts one scheduler grant at a time, pops the head descriptor of the
// granted VOQ, then streams the packet's segment addresses one beat per
// accepted handshake.
// Descriptor layout (32 bits): {addr, ts, len}, with len in the low bits.
// Optional feature macro VDQ_LATENCY_EN: when defined, the enqueue timestamp
// is kept and pkt_latency reports cur_time - ts at packet completion; when
// undefined, pkt_latency is tied to 0 and no timestamp register exists.
module voq_dequeue_ctrl #(
  parameter int EGRESS_CNT = 4,
  parameter int ADDR_WIDTH = 10,
  parameter int TS_WIDTH   = 11,
  parameter int LEN_WIDTH  = 11,
  parameter int SEG_BYTES  = 32
) (
  input  logic                clk,
  input  logic                reset,
  voq_dequeue_ctrl_if.master  bus,
  input  logic [TS_WIDTH-1:0] cur_time,
  output logic                pkt_done,
  output logic [TS_WIDTH-1:0] pkt_latency,
  output logic [15:0]         empty_grant_cnt,
  output logic                busy
);

  localparam int SEL_W     = (EGRESS_CNT > 1) ? $clog2(EGRESS_CNT) : 1;
  localparam int SEG_SHIFT = $clog2(SEG_BYTES);
  localparam int CNT_W     = LEN_WIDTH + 1;
  localparam logic [CNT_W-1:0] REM_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] REM_TWO = CNT_W'(2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_POP,
    S_META,
    S_STREAM
  } state_t;

  // Segments needed for a packet of len bytes; an empty packet still takes one beat.
  function automatic logic [CNT_W-1:0] seg_count(input logic [LEN_WIDTH-1:0] len);
    logic [CNT_W-1:0] sum;
    sum = {1'b0, len} + CNT_W'(SEG_BYTES - 1);
    if (len == '0) return REM_ONE;
    return sum >> SEG_SHIFT;
  endfunction

  state_t                r_state;
  logic                  r_sched_ready;
  logic                  r_deq_en;
  logic [SEL_W-1:0]      r_deq_sel;
  logic                  r_seg_valid;
  logic [ADDR_WIDTH-1:0] r_seg_addr;
  logic                  r_seg_first;
  logic                  r_seg_last;
  logic [CNT_W-1:0]      r_remaining;
  logic                  r_pkt_done;
  logic [15:0]           r_empty_cnt;
  logic                  r_busy;

  logic [ADDR_WIDTH-1:0] w_meta_addr;
  logic [TS_WIDTH-1:0]   w_meta_ts;
  logic [LEN_WIDTH-1:0]  w_meta_len;
  logic [CNT_W-1:0]      w_meta_nseg;
  logic                  w_grant_take;
  logic                  w_sel_empty;
  logic                  w_beat_acc;
  logic                  w_done;

  assign w_meta_addr  = bus.meta_out[LEN_WIDTH+TS_WIDTH +: ADDR_WIDTH];
  assign w_meta_ts    = bus.meta_out[LEN_WIDTH +: TS_WIDTH];
  assign w_meta_len   = bus.meta_out[0 +: LEN_WIDTH];
  assign w_meta_nseg  = seg_count(w_meta_len);
  assign w_grant_take = (r_state == S_IDLE) && r_sched_ready && bus.sched_valid;
  assign w_sel_empty  = bus.is_empty[bus.sched_sel];
  assign w_beat_acc   = r_seg_valid && bus.seg_ready;
  assign w_done       = (r_state == S_STREAM) && w_beat_acc && (r_remaining == REM_ONE);

  // Main controller FSM; every output is a register updated on state transitions.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_sched_ready <= 1'b0;
      r_deq_en      <= 1'b0;
      r_deq_sel     <= '0;
      r_seg_valid   <= 1'b0;
      r_seg_addr    <= '0;
      r_seg_first   <= 1'b0;
      r_seg_last    <= 1'b0;
      r_remaining   <= '0;
      r_pkt_done    <= 1'b0;
      r_empty_cnt   <= '0;
      r_busy        <= 1'b0;
    end else begin
      r_deq_en   <= 1'b0;
      r_pkt_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_sched_ready <= 1'b1;
          if (w_grant_take) begin
            if (w_sel_empty) begin
              if (r_empty_cnt != 16'hFFFF) r_empty_cnt <= r_empty_cnt + 16'd1;
            end else begin
              r_deq_sel     <= bus.sched_sel;
              r_deq_en      <= 1'b1;
              r_sched_ready <= 1'b0;
              r_busy        <= 1'b1;
              r_state       <= S_POP;
            end
          end
        end
        S_POP: begin
          r_state <= S_META;
        end
        S_META: begin
          r_seg_addr  <= w_meta_addr;
          r_remaining <= w_meta_nseg;
          r_seg_first <= 1'b1;
          r_seg_last  <= (w_meta_nseg == REM_ONE);
          r_seg_valid <= 1'b1;
          r_state     <= S_STREAM;
        end
        S_STREAM: begin
          if (w_beat_acc) begin
            if (r_remaining == REM_ONE) begin
              r_seg_valid   <= 1'b0;
              r_seg_first   <= 1'b0;
              r_seg_last    <= 1'b0;
              r_pkt_done    <= 1'b1;
              r_busy        <= 1'b0;
              r_sched_ready <= 1'b1;
              r_state       <= S_IDLE;
            end else begin
              r_seg_addr  <= r_seg_addr + 1'b1;
              r_remaining <= r_remaining - 1'b1;
              r_seg_first <= 1'b0;
              r_seg_last  <= (r_remaining == REM_TWO);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef VDQ_LATENCY_EN
  // Wrap-safe difference of two timestamps on the same free-running base.
  function automatic logic [TS_WIDTH-1:0] ts_delta(input logic [TS_WIDTH-1:0] now,
                                                   input logic [TS_WIDTH-1:0] stamp);
    return now - stamp;
  endfunction

  logic [TS_WIDTH-1:0] r_ts;
  logic [TS_WIDTH-1:0] r_pkt_latency;

  // Capture the enqueue stamp with the descriptor; report latency on completion.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ts          <= '0;
      r_pkt_latency <= '0;
    end else begin
      if (r_state == S_META) r_ts <= w_meta_ts;
      if (w_done) r_pkt_latency <= ts_delta(cur_time, r_ts);
    end
  end

  assign pkt_latency = r_pkt_latency;
`else
  logic w_unused_ts;
  assign w_unused_ts = ^{w_meta_ts, cur_time};
  assign pkt_latency = '0;
`endif

  assign bus.sched_ready     = r_sched_ready;
  assign bus.voq_dequeue_en  = r_deq_en;
  assign bus.voq_dequeue_sel = r_deq_sel;
  assign bus.seg_valid       = r_seg_valid;
  assign bus.seg_addr        = r_seg_addr;
  assign bus.seg_first       = r_seg_first;
  assign bus.seg_last        = r_seg_last;
  assign pkt_done            = r_pkt_done;
  assign empty_grant_cnt     = r_empty_cnt;
  assign busy                = r_busy;

endmodule

// File: tb/tb_voq_dequeue_ctrl.sv
// Directed bench for voq_dequeue_ctrl (default parameters).
// Expected segment beats are queued when a packet is launched and popped as
// the DUT presents them.
module tb_voq_dequeue_ctrl;

  logic        clk;
  logic        reset;
  logic [10:0] cur_time;
  logic        pkt_done;
  logic [10:0] pkt_latency;
  logic [15:0] empty_grant_cnt;
  logic        busy;

  int passed = 0;
  int total  = 0;

  typedef struct packed {
    logic [9:0] addr;
    logic       first;
    logic       last;
  } beat_t;

  beat_t exp_q[$];

  voq_dequeue_ctrl_if #(.EGRESS_CNT(4), .ADDR_WIDTH(10)) bus_if ();

  voq_dequeue_ctrl #(
    .EGRESS_CNT(4), .ADDR_WIDTH(10), .TS_WIDTH(11), .LEN_WIDTH(11), .SEG_BYTES(32)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .bus             (bus_if),
    .cur_time        (cur_time),
    .pkt_done        (pkt_done),
    .pkt_latency     (pkt_latency),
    .empty_grant_cnt (empty_grant_cnt),
    .busy            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] exp_latency(input int cur, input int ts);
`ifdef VDQ_LATENCY_EN
    logic [10:0] d;
    d = 11'(cur - ts);
    return d;
`else
    return 11'd0;
`endif
  endfunction

  // Launch one grant for a non-empty VOQ and check pop, stream and completion.
  task automatic run_packet(input int sel, input int addr, input int ts, input int len,
                            input bit toggle, input int cur);
    int nseg;
    int k;
    bit acc;
    bit lastb;
    beat_t e;
    cur_time = 11'(cur);
    bus_if.is_empty = 4'b0000;
    bus_if.meta_out = 32'hFFFF_FFFF;
    nseg = (len == 0) ? 1 : (len + 31) / 32;
    for (int i = 0; i < nseg; i++) begin
      e.addr  = 10'(addr + i);
      e.first = (i == 0);
      e.last  = (i == nseg - 1);
      exp_q.push_back(e);
    end
    chk("ready_before_grant", bus_if.sched_ready, 1);
    bus_if.sched_valid = 1'b1;
    bus_if.sched_sel   = 2'(sel);
    tick();
    bus_if.sched_valid = 1'b0;
    chk("pop_en", bus_if.voq_dequeue_en, 1);
    chk("pop_sel", bus_if.voq_dequeue_sel, sel);
    chk("pop_ready_low", bus_if.sched_ready, 0);
    chk("pop_busy", busy, 1);
    bus_if.meta_out = {10'(addr), 11'(ts), 11'(len)};
    tick();
    chk("meta_pop_off", bus_if.voq_dequeue_en, 0);
    chk("meta_no_seg", bus_if.seg_valid, 0);
    tick();
    bus_if.meta_out = 32'hFFFF_FFFF;
    k = 0;
    while (exp_q.size() > 0 && k < 200) begin
      bus_if.seg_ready = toggle ? (k % 2 == 0) : 1'b1;
      e = exp_q[0];
      chk("seg_valid", bus_if.seg_valid, 1);
      chk("seg_addr", bus_if.seg_addr, e.addr);
      chk("seg_first", bus_if.seg_first, e.first);
      chk("seg_last", bus_if.seg_last, e.last);
      acc   = bus_if.seg_ready;
      lastb = e.last;
      tick();
      k++;
      if (acc) begin
        void'(exp_q.pop_front());
        if (lastb) begin
          chk("done_pulse", pkt_done, 1);
          chk("latency", pkt_latency, exp_latency(cur, ts));
          chk("idle_seg_valid", bus_if.seg_valid, 0);
          chk("idle_busy", busy, 0);
          chk("idle_ready", bus_if.sched_ready, 1);
        end else begin
          chk("no_early_done", pkt_done, 0);
        end
      end else begin
        chk("no_done_on_stall", pkt_done, 0);
      end
    end
    if (exp_q.size() != 0) begin
      chk("stream_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    bus_if.seg_ready = 1'b0;
    tick();
    chk("done_one_cycle", pkt_done, 0);
    chk("latency_held", pkt_latency, exp_latency(cur, ts));
  endtask

  initial begin
    reset               = 1'b0;
    cur_time            = '0;
    bus_if.sched_valid  = 1'b0;
    bus_if.sched_sel    = '0;
    bus_if.is_empty     = 4'b0000;
    bus_if.meta_out     = '0;
    bus_if.seg_ready    = 1'b0;

    // 1: reset state, then idle after release
    tick();
    tick();
    chk("rst_ready", bus_if.sched_ready, 0);
    chk("rst_seg_valid", bus_if.seg_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", empty_grant_cnt, 0);
    reset = 1'b1;
    tick();
    tick();
    chk("idle_ready_up", bus_if.sched_ready, 1);
    chk("idle_busy0", busy, 0);
    chk("idle_pop0", bus_if.voq_dequeue_en, 0);
    chk("idle_done0", pkt_done, 0);
    chk("idle_lat0", pkt_latency, 0);
    chk("idle_addr0", bus_if.seg_addr, 0);

    // 2: two-segment packet from VOQ 2
    run_packet(2, 5, 100, 64, 1'b0, 300);

    // 3: grant on an empty VOQ is discarded and counted
    chk("empty_cnt_before", empty_grant_cnt, 0);
    bus_if.is_empty    = 4'b0010;
    bus_if.sched_valid = 1'b1;
    bus_if.sched_sel   = 2'd1;
    tick();
    bus_if.sched_valid = 1'b0;
    chk("empty_no_pop", bus_if.voq_dequeue_en, 0);
    chk("empty_cnt_after", empty_grant_cnt, 1);
    chk("empty_busy", busy, 0);
    tick();
    chk("empty_no_pop_later", bus_if.voq_dequeue_en, 0);
    chk("empty_cnt_stable", empty_grant_cnt, 1);

    // 4: address wrap with back-pressure
    run_packet(0, 10'h3FF, 50, 96, 1'b1, 60);

    // 5: zero-length packet, and timestamp wrap
    run_packet(3, 7, 9, 0, 1'b0, 20);
    run_packet(1, 100, 2040, 33, 1'b0, 5);

    // 6: reset during STREAM of a 4-segment packet
    bus_if.is_empty    = 4'b0000;
    bus_if.sched_valid = 1'b1;
    bus_if.sched_sel   = 2'd0;
    tick();
    bus_if.sched_valid = 1'b0;
    bus_if.meta_out    = {10'd20, 11'd0, 11'd128};
    tick();
    tick();
    chk("mid_seg_valid", bus_if.seg_valid, 1);
    chk("mid_addr0", bus_if.seg_addr, 20);
    tick();
    chk("mid_hold_addr", bus_if.seg_addr, 20);
    chk("mid_hold_first", bus_if.seg_first, 1);
    bus_if.seg_ready = 1'b1;
    tick();
    bus_if.seg_ready = 1'b0;
    chk("mid_addr1", bus_if.seg_addr, 21);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_seg_valid", bus_if.seg_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_addr", bus_if.seg_addr, 0);
    chk("arst_cnt", empty_grant_cnt, 0);
    chk("arst_done", pkt_done, 0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("post_rst_done", pkt_done, 0);
    tick();
    chk("post_rst_ready", bus_if.sched_ready, 1);
    chk("post_rst_busy", busy, 0);
    run_packet(0, 200, 10, 128, 1'b0, 40);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
